// File: rtl/dram_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, counter width, byte lanes.
// No logic; latency and backpressure are defined by the modules that import it.
package dram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int WAIT_W = 4;

    localparam int LANE0 = 0;
    localparam int LANE1 = 1;
    localparam int LANE2 = 2;
    localparam int LANE3 = 3;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input int lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/dram_responder_wait_fsm.sv
// Access sequencer: IDLE -> BUSY (WAIT_CYCLES+1 cycles) -> ACK; fire strobes in the last BUSY cycle.
// Latency WAIT_CYCLES+2 cycles to ack; dropping ce while BUSY aborts back to IDLE without firing.
module dram_wait_fsm
    import dram_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    output logic fire,
    output logic ack
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              ack_q, ack_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ce) begin
                    state_d = ST_BUSY;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_BUSY: begin
                if (!ce) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    fire    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            // ce is ignored here: the core advances on the edge leaving ACK
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack = ack_q;

endmodule

// File: rtl/dram_responder.sv
// Four-bank byte-lane data memory behind the MEM-stage load/store port.
// Latency WAIT_CYCLES+2 stall cycles then a one-cycle ack; stall_req holds the pipeline meanwhile.
module dram_responder
    import dram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        stall_req
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    // Banks are not reset; benches preload and inspect them hierarchically.
    logic [7:0] bank0 [0:DEPTH-1];
    logic [7:0] bank1 [0:DEPTH-1];
    logic [7:0] bank2 [0:DEPTH-1];
    logic [7:0] bank3 [0:DEPTH-1];

    logic                  fire;
    logic [ADDR_WIDTH-1:0] word;
    logic                  unused_addr;

    // High bits alias and addr[1:0] is ignored; lanes come only from mem_sel.
    assign word        = mem_addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

    dram_wait_fsm #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_fsm (
        .clk  (clk),
        .rst_n(rst_n),
        .ce   (mem_ce),
        .fire (fire),
        .ack  (mem_ack)
    );

    assign stall_req = mem_ce & ~mem_ack;

    always_ff @(posedge clk) begin
        if (fire && mem_we) begin
            if (mem_sel[LANE0]) bank0[word] <= lane_byte(mem_wdata, LANE0);
            if (mem_sel[LANE1]) bank1[word] <= lane_byte(mem_wdata, LANE1);
            if (mem_sel[LANE2]) bank2[word] <= lane_byte(mem_wdata, LANE2);
            if (mem_sel[LANE3]) bank3[word] <= lane_byte(mem_wdata, LANE3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata <= '0;
        end else if (fire && !mem_we) begin
            mem_rdata <= {bank3[word], bank2[word], bank1[word], bank0[word]};
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: directed table, multi-cycle corner sequences, random accesses vs a word-array model.
module tb_dram_responder;

    logic        clk;
    logic        rst_n;

    logic        ce_a, we_a, ack_a, stall_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  sel_a;

    logic        ce_b, we_b, ack_b, stall_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  sel_b;

    int n_total = 0;
    int n_pass  = 0;
    int ack_pulses_a = 0;

    logic [31:0] mdl_mem [1024];
    logic [31:0] mdl_rdata;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
    } vec_t;

    vec_t tbl [4];

    dram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_ce   (ce_a),
        .mem_we   (we_a),
        .mem_addr (addr_a),
        .mem_sel  (sel_a),
        .mem_wdata(wdata_a),
        .mem_rdata(rdata_a),
        .mem_ack  (ack_a),
        .stall_req(stall_a)
    );

    dram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_ce   (ce_b),
        .mem_we   (we_b),
        .mem_addr (addr_b),
        .mem_sel  (sel_b),
        .mem_wdata(wdata_b),
        .mem_rdata(rdata_b),
        .mem_ack  (ack_b),
        .stall_req(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (ack_a === 1'b1) ack_pulses_a++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % 1024);
    endfunction

    function automatic logic [31:0] peek_a(input int w);
        return {dut_a.bank3[w], dut_a.bank2[w], dut_a.bank1[w], dut_a.bank0[w]};
    endfunction

    function automatic logic [31:0] peek_b(input int w);
        return {dut_b.bank3[w], dut_b.bank2[w], dut_b.bank1[w], dut_b.bank0[w]};
    endfunction

    task automatic model_apply(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] wdata);
        int w;
        w = widx(addr);
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (sel[i]) mdl_mem[w][8*i +: 8] = wdata[8*i +: 8];
        end else begin
            mdl_rdata = mdl_mem[w];
        end
    endtask

    task automatic drive(input bit use_b, input bit ce, input bit we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata);
        if (use_b) begin
            ce_b = ce; we_b = we; addr_b = addr; sel_b = sel; wdata_b = wdata;
        end else begin
            ce_a = ce; we_a = we; addr_a = addr; sel_a = sel; wdata_a = wdata;
        end
    endtask

    // Presents a request at the next negedge and holds it until ack (or the cycle budget runs out).
    task automatic access(input bit use_b, input bit we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          output int stalls, output bit acked, output bit stall_at_ack);
        @(negedge clk);
        drive(use_b, 1'b1, we, addr, sel, wdata);
        stalls = 0;
        acked = 1'b0;
        stall_at_ack = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (use_b ? ack_b : ack_a) begin
                acked = 1'b1;
                stall_at_ack = use_b ? stall_b : stall_a;
                break;
            end
            if (use_b ? stall_b : stall_a) stalls++;
            @(negedge clk);
        end
    endtask

    task automatic release_bus(input bit use_b);
        @(negedge clk);
        drive(use_b, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic checked_access_a(input string tag, input bit we, input logic [31:0] addr,
                                    input logic [3:0] sel, input logic [31:0] wdata);
        int stalls;
        bit acked, sa;
        access(1'b0, we, addr, sel, wdata, stalls, acked, sa);
        chk({tag, "_acked"}, 32'(acked), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'd4);
        chk({tag, "_stall_in_ack"}, 32'(sa), 32'd0);
        model_apply(we, addr, sel, wdata);
        chk({tag, "_rdata"}, rdata_a, mdl_rdata);
        if (we) chk({tag, "_word"}, peek_a(widx(addr)), mdl_mem[widx(addr)]);
    endtask

    initial begin
        int          stalls, pulses0;
        bit          acked, sa;
        bit          we;
        logic [31:0] addr, wdata;
        logic [3:0]  sel;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int k = 0; k < 1024; k++) begin
            mdl_mem[k] = 32'h0;
            {dut_a.bank3[k], dut_a.bank2[k], dut_a.bank1[k], dut_a.bank0[k]} = 32'h0;
            {dut_b.bank3[k], dut_b.bank2[k], dut_b.bank1[k], dut_b.bank0[k]} = 32'h0;
        end
        dut_a.bank0[0] = 8'h44; dut_a.bank1[0] = 8'h33;
        dut_a.bank2[0] = 8'h22; dut_a.bank3[0] = 8'h11;
        mdl_mem[0] = 32'h11223344;
        {dut_a.bank3[3], dut_a.bank2[3], dut_a.bank1[3], dut_a.bank0[3]} = 32'hCAFEF00D;
        mdl_mem[3] = 32'hCAFEF00D;
        {dut_b.bank3[0], dut_b.bank2[0], dut_b.bank1[0], dut_b.bank0[0]} = 32'h55667788;
        mdl_rdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("reset_rdata_a", rdata_a, 32'h0);
        chk("reset_ack_a", 32'(ack_a), 32'd0);
        chk("reset_stall_a", 32'(stall_a), 32'd0);
        chk("reset_rdata_b", rdata_b, 32'h0);
        #3 rst_n = 1'b1;

        // Directed table, applied back-to-back with no idle cycle between requests.
        tbl[0] = '{1'b0, 32'h0000_0000, 4'hF,    32'h0,          32'h11223344, 32'h11223344};
        tbl[1] = '{1'b1, 32'h0000_0004, 4'b0101, 32'hAABBCCDD,   32'h11223344, 32'h00BB00DD};
        tbl[2] = '{1'b1, 32'h0000_0008, 4'hF,    32'hDEADBEEF,   32'h11223344, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 32'h0000_0008, 4'b0001, 32'h0,          32'hDEADBEEF, 32'hDEADBEEF};
        pulses0 = ack_pulses_a;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].wdata, stalls, acked, sa);
            chk($sformatf("tbl%0d_acked", i), 32'(acked), 32'd1);
            chk($sformatf("tbl%0d_stall_cycles", i), 32'(stalls), 32'd4);
            chk($sformatf("tbl%0d_stall_in_ack", i), 32'(sa), 32'd0);
            chk($sformatf("tbl%0d_rdata", i), rdata_a, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_word", i), peek_a(widx(tbl[i].addr)), tbl[i].exp_word);
            model_apply(tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].wdata);
        end
        release_bus(1'b0);
        #1 chk("tbl_ack_pulses", 32'(ack_pulses_a - pulses0), 32'd4);

        // Abort: ce dropped in the second BUSY cycle of a store to word 0.
        pulses0 = ack_pulses_a;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF);
        #1 chk("abort_stall_at_drop", 32'(stall_a), 32'd0);
        @(negedge clk);
        #1 chk("abort_stall_after", 32'(stall_a), 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_ack", 32'(ack_pulses_a - pulses0), 32'd0);
        chk("abort_word0", peek_a(0), 32'h11223344);
        checked_access_a("abort_reload", 1'b0, 32'h0, 4'hF, 32'h0);
        release_bus(1'b0);

        // Asynchronous reset while a store to word 3 is in BUSY.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_000C, 4'hF, 32'h12345678);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_rdata", rdata_a, 32'h0);
        chk("rst_mid_ack", 32'(ack_a), 32'd0);
        mdl_rdata = 32'h0;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_word3", peek_a(3), 32'hCAFEF00D);
        checked_access_a("rst_reload", 1'b0, 32'h0000_000C, 4'h0, 32'h0);
        release_bus(1'b0);

        // Zero wait cycles, aliased addresses.
        access(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0, stalls, acked, sa);
        chk("w0_load_acked", 32'(acked), 32'd1);
        chk("w0_load_stall_cycles", 32'(stalls), 32'd2);
        chk("w0_load_stall_in_ack", 32'(sa), 32'd0);
        chk("w0_load_rdata", rdata_b, 32'h55667788);
        access(1'b1, 1'b1, 32'hFFFF_F007, 4'b1010, 32'h01020304, stalls, acked, sa);
        chk("w0_store_stall_cycles", 32'(stalls), 32'd2);
        chk("w0_store_rdata_kept", rdata_b, 32'h55667788);
        chk("w0_store_word1", peek_b(1), 32'h01000300);
        access(1'b1, 1'b1, 32'h0000_0004, 4'h0, 32'hFFFFFFFF, stalls, acked, sa);
        chk("w0_nosel_acked", 32'(acked), 32'd1);
        access(1'b1, 1'b0, 32'h0000_2004, 4'h1, 32'h0, stalls, acked, sa);
        chk("w0_alias_load_rdata", rdata_b, 32'h01000300);
        release_bus(1'b1);

        // Random accesses against the word-array model, with occasional idle gaps.
        pulses0 = ack_pulses_a;
        for (int n = 0; n < 40; n++) begin
            we    = 1'($urandom_range(0, 1));
            sel   = 4'($urandom_range(0, 15));
            wdata = $urandom;
            if ($urandom_range(0, 3) == 0) addr = $urandom;
            else addr = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
            checked_access_a($sformatf("rnd%0d", n), we, addr, sel, wdata);
            if ($urandom_range(0, 2) == 0) release_bus(1'b0);
        end
        release_bus(1'b0);
        #1 chk("rnd_ack_pulses", 32'(ack_pulses_a - pulses0), 32'd40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
